data_sram_responder: RTL and testbench

//  Responder side of the data SRAM interface driven by the EX stage: accepts one request per

---
 rtl/data_sram_responder_pkg.sv | 39 +++
 rtl/sram_lat_pipe.sv | 62 ++++++
 rtl/data_sram_responder.sv | 118 +++++++++++
 tb/tb_data_sram_responder.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/data_sram_responder_pkg.sv
// Shared definitions for the data SRAM interface (EX stage, MEM stage, responder).
// Bus-width macros are provided for files that prefer `define-style widths; the
// package mirrors them as typed localparams and adds the response slot type.

`ifndef DATA_SRAM_DEFINES
`define DATA_SRAM_DEFINES
`define DATA_SRAM_AW  32
`define DATA_SRAM_DW  32
`define DATA_SRAM_WEW 4
`endif

package data_sram_responder_pkg;

  localparam int unsigned SramAw  = `DATA_SRAM_AW;
  localparam int unsigned SramDw  = `DATA_SRAM_DW;
  localparam int unsigned SramWew = `DATA_SRAM_WEW;

  typedef enum logic [1:0] {
    ReqNone,
    ReqRead,
    ReqWrite
  } req_kind_e;

  // One response slot travelling down the latency pipeline.
  typedef struct packed {
    logic              valid;
    logic              err;
    logic [SramDw-1:0] data;
  } rsp_t;

  // A request with no byte enables set is a read.
  function automatic req_kind_e req_kind(input logic en, input logic [SramWew-1:0] we);
    if (!en) begin
      return ReqNone;
    end
    return (we == '0) ? ReqRead : ReqWrite;
  endfunction

endpackage

// File: rtl/sram_lat_pipe.sv
// Response latency shift register for the data SRAM responder.
// Ports:
//   clk, resetn            clock and synchronous active-low flush
//   in_valid/in_err/in_data    response slot entering the pipe
//   out_valid/out_err/out_data response slot leaving the pipe, DEPTH cycles later
// The data field of a stage only advances with a valid slot, so the last stage always
// shows the most recent read data (rdata hold behaviour). DEPTH=0 is a plain wire.

module sram_lat_pipe #(
  parameter int unsigned DEPTH = 0,
  parameter int unsigned DW    = 32
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          in_valid,
  input  logic          in_err,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  output logic          out_err,
  output logic [DW-1:0] out_data
);

  if (DEPTH == 0) begin : g_wire
    logic unused_ctrl;
    assign unused_ctrl = clk ^ resetn;
    assign out_valid   = in_valid;
    assign out_err     = in_err;
    assign out_data    = in_data;
  end else begin : g_pipe
    logic          valid_q [DEPTH];
    logic          err_q   [DEPTH];
    logic [DW-1:0] data_q  [DEPTH];

    always_ff @(posedge clk) begin
      if (!resetn) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
          valid_q[i] <= 1'b0;
          err_q[i]   <= 1'b0;
          data_q[i]  <= '0;
        end
      end else begin
        valid_q[0] <= in_valid;
        err_q[0]   <= in_err;
        if (in_valid) begin
          data_q[0] <= in_data;
        end
        for (int i = 1; i < int'(DEPTH); i++) begin
          valid_q[i] <= valid_q[i-1];
          err_q[i]   <= err_q[i-1];
          if (valid_q[i-1]) begin
            data_q[i] <= data_q[i-1];
          end
        end
      end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_err   = err_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];
  end

endmodule

// File: rtl/data_sram_responder.sv
// Data SRAM responder: word-addressed RAM behind the EX-stage data SRAM interface.
// Accepts one request per cycle, never back-pressures, byte-lane writes, read data
// returned READ_LATENCY cycles after the request edge.
// Ports:
//   clk, resetn        clock, synchronous active-low reset (array contents not reset)
//   data_sram_en       request valid
//   data_sram_we       byte write enables, all-zero means read
//   data_sram_addr     byte address, bits [1:0] ignored
//   data_sram_wdata    write data
//   data_sram_rdata    read data, holds between responses
//   data_sram_rvalid   pulse: rdata carries a read response
//   data_sram_err      pulse: the slot's request was out of range

module data_sram_responder
  import data_sram_responder_pkg::*;
#(
  parameter int unsigned ADDR_BITS    = 12,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               data_sram_en,
  input  logic [SramWew-1:0] data_sram_we,
  input  logic [SramAw-1:0]  data_sram_addr,
  input  logic [SramDw-1:0]  data_sram_wdata,
  output logic [SramDw-1:0]  data_sram_rdata,
  output logic               data_sram_rvalid,
  output logic               data_sram_err
);

  if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
    $error("data_sram_responder: READ_LATENCY must be within 1..4");
  end
  if (BASE_ADDR[1:0] != 2'b00) begin : g_bad_base
    $error("data_sram_responder: BASE_ADDR must be 4-byte aligned");
  end

  // Decode
  logic [SramAw-1:0]    off;
  logic                 in_range;
  logic [ADDR_BITS-1:0] idx;
  req_kind_e            kind;
  logic                 wr_hit;
  logic                 rd_hit;

  assign off      = data_sram_addr - BASE_ADDR;
  assign in_range = (off >> (ADDR_BITS + 2)) == '0;
  assign idx      = off[ADDR_BITS+1:2];
  assign kind     = req_kind(data_sram_en, data_sram_we);
  assign wr_hit   = resetn && (kind == ReqWrite) && in_range;
  assign rd_hit   = resetn && (kind == ReqRead) && in_range;

  // Array with byte-lane write enables and a registered, read-enabled port (BRAM style).
  logic [SramDw-1:0] mem [2**ADDR_BITS];
  logic [SramDw-1:0] mem_rdata_q;

  always_ff @(posedge clk) begin
    if (wr_hit) begin
      for (int i = 0; i < int'(SramWew); i++) begin
        if (data_sram_we[i]) begin
          mem[idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
        end
      end
    end
    if (rd_hit) begin
      mem_rdata_q <= mem[idx];
    end
  end

  // First response stage. s1_zero_q masks the array output after reset or an
  // out-of-range read, so the held data value is correct without resetting the RAM port.
  logic s1_valid_q;
  logic s1_err_q;
  logic s1_zero_q;
  rsp_t s1_rsp;
  rsp_t out_rsp;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      s1_valid_q <= 1'b0;
      s1_err_q   <= 1'b0;
      s1_zero_q  <= 1'b1;
    end else begin
      s1_valid_q <= (kind == ReqRead);
      s1_err_q   <= (kind != ReqNone) && !in_range;
      if (kind == ReqRead) begin
        s1_zero_q <= !in_range;
      end
    end
  end

  always_comb begin
    s1_rsp       = '0;
    s1_rsp.valid = s1_valid_q;
    s1_rsp.err   = s1_err_q;
    s1_rsp.data  = s1_zero_q ? '0 : mem_rdata_q;
  end

  sram_lat_pipe #(
    .DEPTH (READ_LATENCY - 1),
    .DW    (SramDw)
  ) u_lat_pipe (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (s1_rsp.valid),
    .in_err    (s1_rsp.err),
    .in_data   (s1_rsp.data),
    .out_valid (out_rsp.valid),
    .out_err   (out_rsp.err),
    .out_data  (out_rsp.data)
  );

  assign data_sram_rdata  = out_rsp.data;
  assign data_sram_rvalid = out_rsp.valid;
  assign data_sram_err    = out_rsp.err;

endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder: two instances (READ_LATENCY 1 and 3) share one
// request stream. Each driven request pushes its expected response slot onto a
// per-instance queue; the slot is popped and compared when that instance's latency
// has elapsed. Idle cycles expect no pulse and held rdata.

module tb_data_sram_responder;

  logic        clk = 1'b0;
  logic        resetn;
  logic        en;
  logic [3:0]  we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata1, rdata3;
  logic        rvalid1, rvalid3;
  logic        err1, err3;

  always #5 clk = ~clk;

  data_sram_responder #(
    .ADDR_BITS    (12),
    .BASE_ADDR    (32'h0000_0000),
    .READ_LATENCY (1)
  ) u_dut1 (
    .clk              (clk),
    .resetn           (resetn),
    .data_sram_en     (en),
    .data_sram_we     (we),
    .data_sram_addr   (addr),
    .data_sram_wdata  (wdata),
    .data_sram_rdata  (rdata1),
    .data_sram_rvalid (rvalid1),
    .data_sram_err    (err1)
  );

  data_sram_responder #(
    .ADDR_BITS    (12),
    .BASE_ADDR    (32'h0000_0000),
    .READ_LATENCY (3)
  ) u_dut3 (
    .clk              (clk),
    .resetn           (resetn),
    .data_sram_en     (en),
    .data_sram_we     (we),
    .data_sram_addr   (addr),
    .data_sram_wdata  (wdata),
    .data_sram_rdata  (rdata3),
    .data_sram_rvalid (rvalid3),
    .data_sram_err    (err3)
  );

  typedef struct {
    bit        valid;
    bit        err;
    bit [31:0] data;
  } slot_t;

  typedef struct {
    bit        en;
    bit [3:0]  we;
    bit [31:0] addr;
    bit [31:0] wdata;
    bit        ev;
    bit        ee;
    bit [31:0] ed;
    string     name;
  } vec_t;

  slot_t     q1[$];
  slot_t     q3[$];
  bit [31:0] held1;
  bit [31:0] held3;
  int        checks;
  int        errors;
  vec_t      vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic score(input string tag, input bit have, input slot_t s, inout bit [31:0] held,
                       input logic [31:0] rd, input logic rv, input logic er);
    slot_t e;
    e.valid = 1'b0;
    e.err   = 1'b0;
    e.data  = '0;
    if (have) e = s;
    if (e.valid) held = e.data;
    check({tag, " rvalid"}, {31'b0, rv}, {31'b0, e.valid});
    check({tag, " err"}, {31'b0, er}, {31'b0, e.err});
    check({tag, " rdata"}, rd, held);
  endtask

  // One request cycle: drive at negedge, account at posedge, sample 1 time unit later.
  task automatic step(input bit rstn, input bit en_v, input bit [3:0] we_v, input bit [31:0] a,
                      input bit [31:0] wd, input bit ev, input bit ee, input bit [31:0] ed,
                      input string name);
    slot_t s;
    slot_t e1;
    slot_t e3;
    bit    h1;
    bit    h3;
    @(negedge clk);
    resetn = rstn;
    en     = en_v;
    we     = we_v;
    addr   = a;
    wdata  = wd;
    @(posedge clk);
    if (!rstn) begin
      q1.delete();
      q3.delete();
      held1 = '0;
      held3 = '0;
    end else begin
      s.valid = ev;
      s.err   = ee;
      s.data  = ed;
      q1.push_back(s);
      q3.push_back(s);
    end
    #1;
    e1 = '{valid: 1'b0, err: 1'b0, data: 32'h0};
    e3 = '{valid: 1'b0, err: 1'b0, data: 32'h0};
    h1 = (q1.size() >= 1);
    if (h1) e1 = q1.pop_front();
    score({name, "/L1"}, h1, e1, held1, rdata1, rvalid1, err1);
    h3 = (q3.size() >= 3);
    if (h3) e3 = q3.pop_front();
    score({name, "/L3"}, h3, e3, held3, rdata3, rvalid3, err3);
  endtask

  task automatic idle(input int n, input string name);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, name);
  endtask

  initial begin
    resetn = 1'b0;
    en     = 1'b0;
    we     = 4'h0;
    addr   = 32'h0;
    wdata  = 32'h0;
    checks = 0;
    errors = 0;
    held1  = '0;
    held3  = '0;

    //             en we     addr          wdata         ev ee ed
    vecs.push_back(vec_t'{1, 4'hF, 32'h0000_0100, 32'h1122_3344, 0, 0, 32'h0, "wr100_full"});
    vecs.push_back(vec_t'{1, 4'h5, 32'h0000_0100, 32'hAABB_CCDD, 0, 0, 32'h0, "wr100_lanes"});
    vecs.push_back(vec_t'{1, 4'h0, 32'h0000_0100, 32'h0, 1, 0, 32'h11BB_33DD, "rd100"});
    vecs.push_back(vec_t'{1, 4'hF, 32'h0000_0024, 32'hCAFE_F00D, 0, 0, 32'h0, "wr24"});
    vecs.push_back(vec_t'{1, 4'hF, 32'h0000_0020, 32'hDEAD_BEEF, 0, 0, 32'h0, "wr20"});
    vecs.push_back(vec_t'{1, 4'h0, 32'h0000_0020, 32'h0, 1, 0, 32'hDEAD_BEEF, "rd20_b2b"});
    vecs.push_back(vec_t'{1, 4'h0, 32'h0000_0024, 32'h0, 1, 0, 32'hCAFE_F00D, "rd24_b2b"});
    vecs.push_back(vec_t'{1, 4'hF, 32'h0000_0000, 32'h0102_0304, 0, 0, 32'h0, "wr0"});
    vecs.push_back(vec_t'{1, 4'hF, 32'h0000_0004, 32'h0506_0708, 0, 0, 32'h0, "wr4"});
    vecs.push_back(vec_t'{1, 4'hF, 32'h0000_0008, 32'h090A_0B0C, 0, 0, 32'h0, "wr8"});
    vecs.push_back(vec_t'{1, 4'hF, 32'h0000_3FFC, 32'h5A5A_A5A5, 0, 0, 32'h0, "wr_top"});
    vecs.push_back(vec_t'{1, 4'h0, 32'h0000_4000, 32'h0, 1, 1, 32'h0, "rd_oor"});
    vecs.push_back(vec_t'{1, 4'hF, 32'h0000_4000, 32'hFFFF_FFFF, 0, 1, 32'h0, "wr_oor"});
    vecs.push_back(vec_t'{1, 4'h0, 32'h0000_0000, 32'h0, 1, 0, 32'h0102_0304, "rd0_after_oor"});
    vecs.push_back(vec_t'{1, 4'h0, 32'h0000_0004, 32'h0, 1, 0, 32'h0506_0708, "rd4_seq"});
    vecs.push_back(vec_t'{1, 4'h0, 32'h0000_0008, 32'h0, 1, 0, 32'h090A_0B0C, "rd8_seq"});
    vecs.push_back(vec_t'{0, 4'hF, 32'h0000_0000, 32'hFFFF_FFFF, 0, 0, 32'h0, "en0_gap"});
    vecs.push_back(vec_t'{1, 4'h0, 32'h0000_3FFF, 32'h0, 1, 0, 32'h5A5A_A5A5, "rd_top_lowbits"});
    vecs.push_back(vec_t'{1, 4'h0, 32'h0000_0000, 32'h0, 1, 0, 32'h0102_0304, "rd0_en0_nowrite"});
    vecs.push_back(vec_t'{1, 4'h0, 32'hFFFF_FFFC, 32'h0, 1, 1, 32'h0, "rd_oor_high"});
    vecs.push_back(vec_t'{1, 4'h0, 32'h0000_0100, 32'h0, 1, 0, 32'h11BB_33DD, "rd100_again"});

    // Reset held with reads in flight, then release with no traffic.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, "rst_hold");
    idle(4, "rst_release");

    foreach (vecs[i]) begin
      step(1'b1, vecs[i].en, vecs[i].we, vecs[i].addr, vecs[i].wdata,
           vecs[i].ev, vecs[i].ee, vecs[i].ed, vecs[i].name);
    end
    idle(4, "drain");

    // Reset one cycle after two reads: the L3 responses must never appear.
    step(1'b1, 1'b1, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0102_0304, "mid_rd0");
    step(1'b1, 1'b1, 4'h0, 32'h4, 32'h0, 1'b1, 1'b0, 32'h0506_0708, "mid_rd4");
    step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, "mid_rst");
    step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, "mid_rst");
    idle(5, "mid_after");

    // Traffic still works after the mid-operation reset.
    step(1'b1, 1'b1, 4'h0, 32'h8, 32'h0, 1'b1, 1'b0, 32'h090A_0B0C, "post_rd8");
    idle(4, "post_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
